// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution address-generation blocks: walk FSM
// state encoding and default bus/field widths.
package cnn_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DIM_W_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier, one multiplier bit per cycle.
// The first partial product is taken in the start cycle, so the result and its
// done pulse appear W cycles after start.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start         load a/b and begin (takes priority over a running product)
//   a, b          W-bit unsigned operands
//   done          one-cycle pulse, product valid from this cycle on
//   product       2W-bit result, held until the next start
module seq_mul
  import cnn_pkg::*;
#(
  parameter int unsigned W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             done,
  output logic [2*W-1:0]   product
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  logic [PW-1:0] mcand_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  // Shift-add iteration; cnt_q holds the number of multiplier bits still to consume.
  always_ff @(posedge clk) begin
    if (!rst) begin
      product  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        product  <= b[0] ? PW'(a) : '0;
        mcand_q  <= PW'(a) << 1;
        mplier_q <= b >> 1;
        cnt_q    <= CW'(W - 1);
        run_q    <= (W > 1);
        done     <= (W == 1);
      end else if (run_q) begin
        if (mplier_q[0]) product <= product + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/conv_win_addr_gen.sv
// Walks a KxK convolution window over a width x height x channel feature map
// and emits the K row-start BRAM addresses of each window with valid/ready.
// Optional build macro: CONV_WIN_ADDR_PERF_EN adds the win_count handshake counter.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   start                    begin a walk (accepted only in IDLE)
//   base_addr                address of pixel (0,0,ch0)
//   width/height/channel     map geometry (channel 0 means 1)
//   stride                   window step (0 means 1)
//   busy                     walk in progress
//   addr_valid/addr_ready    beat handshake
//   addr_out                 slice i = address of window row i, column 0
//   col_idx/row_idx/ch_idx   window origin and channel of the current beat
//   chan_end/img_end         current beat closes its channel / the image
//   done                     one-cycle pulse when the walk ends
//   cfg_err                  last start had width<K or height<K (sticky)
//   win_count                handshake count, saturating (perf build only)
module conv_win_addr_gen
  import cnn_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF,
  parameter int unsigned K      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [DIM_W-1:0]    width,
  input  logic [DIM_W-1:0]    height,
  input  logic [DIM_W-1:0]    channel,
  input  logic [2:0]          stride,
  output logic                busy,
  output logic                addr_valid,
  input  logic                addr_ready,
  output logic [K*ADDR_W-1:0] addr_out,
  output logic [DIM_W-1:0]    col_idx,
  output logic [DIM_W-1:0]    row_idx,
  output logic [DIM_W-1:0]    ch_idx,
  output logic                chan_end,
  output logic                img_end,
  output logic                done,
  output logic                cfg_err
`ifdef CONV_WIN_ADDR_PERF_EN
  ,
  output logic [2*DIM_W-1:0]  win_count
`endif
);

  localparam int unsigned EW = DIM_W + 4;
  localparam int unsigned PW = 2 * DIM_W;

  state_t state, state_nxt;

  logic [DIM_W-1:0]  width_q, height_q, chan_q;
  logic [2:0]        stride_q;
  logic [ADDR_W-1:0] base_q, row_step_q, plane_q, chan_base_q, row_base_q;
  logic [ADDR_W-1:0] addr_q [K];
  logic [ADDR_W-1:0] row_off [K];
  logic [ADDR_W-1:0] row_base_nxt, chan_base_nxt;
  logic              phase;

  logic              cfg_bad, hs, col_fit, row_fit, ch_more;
  logic [DIM_W-1:0]  stride_eff;

  logic              mul_start, mul_done;
  logic [DIM_W-1:0]  mul_a, mul_b;
  logic [PW-1:0]     mul_p;

  // Geometry checks are done wider than DIM_W so col+stride+K cannot wrap.
  assign stride_eff = (stride == 3'd0) ? DIM_W'(1) : DIM_W'(stride);
  assign cfg_bad    = (EW'(width) < EW'(K)) || (EW'(height) < EW'(K));
  assign hs         = addr_valid && addr_ready;
  assign col_fit    = (EW'(col_idx) + EW'(stride_q) + EW'(K)) <= EW'(width_q);
  assign row_fit    = (EW'(row_idx) + EW'(stride_q) + EW'(K)) <= EW'(height_q);
  assign ch_more    = (EW'(ch_idx) + EW'(1)) < EW'(chan_q);
  assign chan_end   = addr_valid && !col_fit && !row_fit;
  assign img_end    = chan_end && !ch_more;

  assign row_base_nxt  = row_base_q + row_step_q;
  assign chan_base_nxt = chan_base_q + plane_q;

  // Offset of window row i from the window's top row (constant-coefficient products).
  always_comb begin
    for (int i = 0; i < K; i++) row_off[i] = ADDR_W'(i) * ADDR_W'(width_q);
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_addr
    assign addr_out[gi*ADDR_W +: ADDR_W] = addr_q[gi];
  end

  // Multiplier sequencing: stride*width launched with the accepted start,
  // width*height launched the cycle the first product lands.
  always_comb begin
    mul_start = 1'b0;
    mul_a     = width_q;
    mul_b     = height_q;
    if (state == IDLE) begin
      mul_a     = stride_eff;
      mul_b     = width;
      mul_start = start && !cfg_bad;
    end else if (state == SETUP) begin
      mul_start = mul_done && !phase;
    end
  end

  seq_mul #(.W(DIM_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .done    (mul_done),
    .product (mul_p)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = cfg_bad ? DONE : SETUP;
      SETUP:   if (mul_done && phase) state_nxt = RUN;
      RUN:     if (hs && img_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    busy       = 1'b0;
    addr_valid = 1'b0;
    done       = 1'b0;
    case (state)
      SETUP:   busy = 1'b1;
      RUN:     begin busy = 1'b1; addr_valid = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Config capture, SETUP products and the window walk (adders only per beat).
  always_ff @(posedge clk) begin
    if (!rst) begin
      width_q     <= '0;
      height_q    <= '0;
      chan_q      <= '0;
      stride_q    <= '0;
      base_q      <= '0;
      row_step_q  <= '0;
      plane_q     <= '0;
      chan_base_q <= '0;
      row_base_q  <= '0;
      phase       <= 1'b0;
      cfg_err     <= 1'b0;
      col_idx     <= '0;
      row_idx     <= '0;
      ch_idx      <= '0;
      for (int i = 0; i < K; i++) addr_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            width_q  <= width;
            height_q <= height;
            chan_q   <= (channel == '0) ? DIM_W'(1) : channel;
            stride_q <= (stride == 3'd0) ? 3'd1 : stride;
            base_q   <= base_addr;
            cfg_err  <= cfg_bad;
            phase    <= 1'b0;
          end
        end
        SETUP: begin
          if (mul_done) begin
            if (!phase) begin
              row_step_q <= ADDR_W'(mul_p);
              phase      <= 1'b1;
            end else begin
              plane_q     <= ADDR_W'(mul_p);
              chan_base_q <= base_q;
              row_base_q  <= base_q;
              col_idx     <= '0;
              row_idx     <= '0;
              ch_idx      <= '0;
              for (int i = 0; i < K; i++) addr_q[i] <= base_q + row_off[i];
            end
          end
        end
        RUN: begin
          if (hs) begin
            if (col_fit) begin
              col_idx <= col_idx + DIM_W'(stride_q);
              for (int i = 0; i < K; i++) addr_q[i] <= addr_q[i] + ADDR_W'(stride_q);
            end else if (row_fit) begin
              row_idx    <= row_idx + DIM_W'(stride_q);
              col_idx    <= '0;
              row_base_q <= row_base_nxt;
              for (int i = 0; i < K; i++) addr_q[i] <= row_base_nxt + row_off[i];
            end else if (ch_more) begin
              ch_idx      <= ch_idx + DIM_W'(1);
              row_idx     <= '0;
              col_idx     <= '0;
              chan_base_q <= chan_base_nxt;
              row_base_q  <= chan_base_nxt;
              for (int i = 0; i < K; i++) addr_q[i] <= chan_base_nxt + row_off[i];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_WIN_ADDR_PERF_EN
  // Saturating handshake counter, cleared by an accepted start.
  always_ff @(posedge clk) begin
    if (!rst)                                   win_count <= '0;
    else if (state == IDLE && start)            win_count <= '0;
    else if (hs && (win_count != '1))           win_count <= win_count + PW'(1);
  end
`endif

endmodule

// File: tb/tb_conv_win_addr_gen.sv
// Scoreboard bench for conv_win_addr_gen: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_conv_win_addr_gen;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DIM_W  = 12;
  localparam int unsigned K      = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       base_addr = '0;
  logic [11:0]       width = '0, height = '0, channel = '0;
  logic [2:0]        stride = '0;
  logic              busy, addr_valid, chan_end, img_end, done, cfg_err;
  logic              addr_ready = 1'b0;
  logic [95:0]       addr_out;
  logic [11:0]       col_idx, row_idx, ch_idx;
`ifdef CONV_WIN_ADDR_PERF_EN
  logic [23:0]       win_count;
`endif

  conv_win_addr_gen #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .K(K)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .width      (width),
    .height     (height),
    .channel    (channel),
    .stride     (stride),
    .busy       (busy),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .col_idx    (col_idx),
    .row_idx    (row_idx),
    .ch_idx     (ch_idx),
    .chan_end   (chan_end),
    .img_end    (img_end),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef CONV_WIN_ADDR_PERF_EN
    ,
    .win_count  (win_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [95:0] addr;
    logic [11:0] col, row, ch;
    logic        ce, ie;
  } beat_t;

  beat_t exp_q[$];
  beat_t act_q[$];
  int    hs_cyc[$];
  int    checks = 0, passes = 0;
  int    done_cnt = 0, valid_cycles = 0, last_hs = -10, start_cyc = 0, first_valid = -1;
  bit    err_mode = 1'b0;
  logic  prev_valid = 1'b0;
  int    n;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [95:0] pk(input int unsigned a0, input int unsigned a1, input int unsigned a2);
    return {32'(a2), 32'(a1), 32'(a0)};
  endfunction

  // Reference walk: direct address formula over nested loops.
  task automatic push_model(input int unsigned b, input int unsigned w, input int unsigned h,
                            input int unsigned ch, input int unsigned s);
    int unsigned se, ce_n;
    beat_t bt;
    se   = (s == 0) ? 1 : s;
    ce_n = (ch == 0) ? 1 : ch;
    for (int unsigned c = 0; c < ce_n; c++)
      for (int unsigned r = 0; r + K <= h; r += se)
        for (int unsigned x = 0; x + K <= w; x += se) begin
          for (int unsigned i = 0; i < K; i++)
            bt.addr[i*32 +: 32] = 32'(b + c*w*h + (r+i)*w + x);
          bt.col = 12'(x);
          bt.row = 12'(r);
          bt.ch  = 12'(c);
          bt.ce  = (r + se + K > h) && (x + se + K > w);
          bt.ie  = bt.ce && (c == ce_n - 1);
          exp_q.push_back(bt);
        end
  endtask

  task automatic clear_tb();
    act_q.delete();
    hs_cyc.delete();
    done_cnt     = 0;
    valid_cycles = 0;
    first_valid  = -1;
    err_mode     = 1'b0;
  endtask

  task automatic kick(input int unsigned b, input int unsigned w, input int unsigned h,
                      input int unsigned ch, input int unsigned s);
    @(posedge clk); #1;
    base_addr = b; width = 12'(w); height = 12'(h); channel = 12'(ch); stride = 3'(s);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble config after acceptance; the walk must use the captured values.
    base_addr = 32'hdead_0000; width = 12'd1; height = 12'd9; channel = 12'd3; stride = 3'd5;
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, 128'(done_cnt != 0), 128'(1));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    beat_t a, e;
    if (rst) begin
      if (addr_valid) valid_cycles++;
      if (addr_valid && !prev_valid && first_valid < 0) first_valid = cyc;
      if (addr_valid && addr_ready) begin
        a.addr = addr_out; a.col = col_idx; a.row = row_idx; a.ch = ch_idx;
        a.ce = chan_end; a.ie = img_end;
        act_q.push_back(a);
        hs_cyc.push_back(cyc);
        last_hs = cyc;
        if (exp_q.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("beat_addr",     128'(addr_out), 128'(e.addr));
          chk("beat_col",      128'(col_idx),  128'(e.col));
          chk("beat_row",      128'(row_idx),  128'(e.row));
          chk("beat_ch",       128'(ch_idx),   128'(e.ch));
          chk("beat_chan_end", 128'(chan_end), 128'(e.ce));
          chk("beat_img_end",  128'(img_end),  128'(e.ie));
        end
      end
      if (done) begin
        done_cnt++;
        if (err_mode) chk("done_timing", 128'(cyc), 128'(start_cyc + 1));
        else          chk("done_timing", 128'(cyc), 128'(last_hs + 1));
      end
      prev_valid = addr_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",     128'(busy),       128'(0));
    chk("rst_valid",    128'(addr_valid), 128'(0));
    chk("rst_done",     128'(done),       128'(0));
    chk("rst_cfg_err",  128'(cfg_err),    128'(0));
    chk("rst_flags",    128'({chan_end, img_end}), 128'(0));
    chk("rst_addr",     128'(addr_out),   128'(0));
    @(posedge clk); #1;
    rst = 1'b1;

    // 5x5, stride 1, base 0
    clear_tb();
    addr_ready = 1'b1;
    push_model(0, 5, 5, 1, 1);
    kick(0, 5, 5, 1, 1);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_done("t1");
    chk("t1_beats", 128'(act_q.size()), 128'(9));
    if (act_q.size() == 9) begin
      chk("t1_b1", 128'(act_q[0].addr), 128'(pk(0, 5, 10)));
      chk("t1_b4", 128'(act_q[3].addr), 128'(pk(5, 10, 15)));
      chk("t1_b9", 128'(act_q[8].addr), 128'(pk(12, 17, 22)));
      chk("t1_b9_flags", 128'({act_q[8].ce, act_q[8].ie}), 128'(2'b11));
      chk("t1_b8_flags", 128'({act_q[7].ce, act_q[7].ie}), 128'(2'b00));
      chk("t1_no_bubble", 128'(hs_cyc[8] - hs_cyc[0]), 128'(8));
    end
    chk("t1_latency", 128'(first_valid - start_cyc), 128'(2*DIM_W + 1));
    chk("t1_done_cnt", 128'(done_cnt), 128'(1));
    chk("t1_idle_busy", 128'(busy), 128'(0));
    chk("t1_q_empty", 128'(exp_q.size()), 128'(0));

    // 7x7, stride 2, base 100
    clear_tb();
    push_model(100, 7, 7, 1, 2);
    kick(100, 7, 7, 1, 2);
    wait_done("t2");
    chk("t2_beats", 128'(act_q.size()), 128'(9));
    if (act_q.size() == 9) begin
      chk("t2_b3_col", 128'(act_q[2].col), 128'(4));
      chk("t2_b4", 128'(act_q[3].addr), 128'(pk(114, 121, 128)));
      chk("t2_b4_row", 128'(act_q[3].row), 128'(2));
    end

    // 4x4, two channels
    clear_tb();
    push_model(0, 4, 4, 2, 1);
    kick(0, 4, 4, 2, 1);
    wait_done("t3");
    chk("t3_beats", 128'(act_q.size()), 128'(8));
    if (act_q.size() == 8) begin
      chk("t3_b5", 128'(act_q[4].addr), 128'(pk(16, 20, 24)));
      chk("t3_b5_ch", 128'(act_q[4].ch), 128'(1));
      chk("t3_b4_flags", 128'({act_q[3].ce, act_q[3].ie}), 128'(2'b10));
      chk("t3_b8_flags", 128'({act_q[7].ce, act_q[7].ie}), 128'(2'b11));
      chk("t3_b1_ce", 128'(act_q[0].ce), 128'(0));
    end

    // Backpressure on beat 2
    clear_tb();
    addr_ready = 1'b0;
    push_model(0, 5, 5, 1, 1);
    kick(0, 5, 5, 1, 1);
    n = 0;
    while (!addr_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_valid_seen", 128'(addr_valid), 128'(1));
    addr_ready = 1'b1;
    @(posedge clk); #1;
    addr_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_addr",  128'(addr_out), 128'(pk(1, 6, 11)));
      chk("t4_hold_idx",   128'({col_idx, row_idx, ch_idx}), 128'({12'd1, 12'd0, 12'd0}));
      chk("t4_hold_valid", 128'({addr_valid, chan_end, img_end}), 128'(3'b100));
      @(posedge clk); #1;
    end
    addr_ready = 1'b1;
    wait_done("t4");
    chk("t4_beats", 128'(act_q.size()), 128'(9));

    // Config error, then recovery
    clear_tb();
    err_mode = 1'b1;
    kick(0, 2, 5, 1, 1);
    wait_done("t5");
    chk("t5_cfg_err", 128'(cfg_err), 128'(1));
    chk("t5_no_valid", 128'(valid_cycles), 128'(0));
    chk("t5_done_cnt", 128'(done_cnt), 128'(1));
    clear_tb();
    push_model(0, 5, 5, 1, 1);
    kick(0, 5, 5, 1, 1);
    @(negedge clk);
    chk("t5_err_cleared", 128'(cfg_err), 128'(0));
    wait_done("t5b");
    chk("t5b_beats", 128'(act_q.size()), 128'(9));

    // Reset mid-RUN, then restart
    clear_tb();
    push_model(0, 5, 5, 1, 1);
    kick(0, 5, 5, 1, 1);
    n = 0;
    while (act_q.size() < 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_state", 128'({busy, addr_valid, done}), 128'(3'b000));
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_no_done", 128'(done_cnt), 128'(0));
    chk("t6_idle", 128'(busy), 128'(0));
    clear_tb();
    push_model(0, 5, 5, 1, 1);
    kick(0, 5, 5, 1, 1);
    wait_done("t6");
    chk("t6_beats", 128'(act_q.size()), 128'(9));
    if (act_q.size() == 9)
      chk("t6_b1", 128'(act_q[0].addr), 128'(pk(0, 5, 10)));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
